mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory read/write channel among NUM_CONSUMERS
// requesters, one transaction in flight at a time.
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration
// (the search starts at a rotating pointer). Leave it undefined for fixed
// priority, where the lowest eligible index always wins.
//
// Every output is registered. All outputs, state and the round-robin pointer
// clear asynchronously while reset is low.
module mem_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
    input  logic [ADDR_BITS*NUM_CONSUMERS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
    output logic [DATA_BITS*NUM_CONSUMERS-1:0]   consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
    input  logic [ADDR_BITS*NUM_CONSUMERS-1:0]   consumer_write_address,
    input  logic [DATA_BITS*NUM_CONSUMERS-1:0]   consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
    output logic                                 mem_read_valid,
    output logic [ADDR_BITS-1:0]                 mem_read_address,
    input  logic                                 mem_read_ready,
    input  logic [DATA_BITS-1:0]                 mem_read_data,
    output logic                                 mem_write_valid,
    output logic [ADDR_BITS-1:0]                 mem_write_address,
    output logic [DATA_BITS-1:0]                 mem_write_data,
    input  logic                                 mem_write_ready,
    output logic [$clog2(NUM_CONSUMERS)-1:0]     grant_id,
    output logic                                 busy
);

    localparam int ID_W = $clog2(NUM_CONSUMERS);

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_READ_WAITING   = 3'd1,
        ST_WRITE_WAITING  = 3'd2,
        ST_READ_RELAYING  = 3'd3,
        ST_WRITE_RELAYING = 3'd4
    } state_t;

    state_t                           state_q, state_d;
    logic [ID_W-1:0]                  grant_id_q, grant_id_d;
    logic                             busy_q, busy_d;
    logic                             mem_read_valid_q, mem_read_valid_d;
    logic [ADDR_BITS-1:0]             mem_read_address_q, mem_read_address_d;
    logic                             mem_write_valid_q, mem_write_valid_d;
    logic [ADDR_BITS-1:0]             mem_write_address_q, mem_write_address_d;
    logic [DATA_BITS-1:0]             mem_write_data_q, mem_write_data_d;
    logic [NUM_CONSUMERS-1:0]         consumer_read_ready_q, consumer_read_ready_d;
    logic [NUM_CONSUMERS-1:0]         consumer_write_ready_q, consumer_write_ready_d;
    logic [DATA_BITS*NUM_CONSUMERS-1:0] consumer_read_data_q, consumer_read_data_d;

    logic [NUM_CONSUMERS-1:0]         eligible_s;
    logic                             win_found_s;
    logic [ID_W-1:0]                  winner_s;

    assign eligible_s = consumer_read_valid | consumer_write_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    // Round-robin pick: first eligible index at or after rr_ptr, wrapping.
    always_comb begin
        logic [ID_W:0]   sum_v;
        logic [ID_W-1:0] cand_v;
        logic            take_v;
        win_found_s = 1'b0;
        winner_s    = '0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            sum_v       = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            sum_v       = (sum_v >= (ID_W+1)'(NUM_CONSUMERS)) ?
                          (sum_v - (ID_W+1)'(NUM_CONSUMERS)) : sum_v;
            cand_v      = sum_v[ID_W-1:0];
            take_v      = eligible_s[cand_v] & ~win_found_s;
            winner_s    = take_v ? cand_v : winner_s;
            win_found_s = win_found_s | take_v;
        end
    end

    // Pointer advances to the index after the winner on every grant.
    always_comb begin
        logic [ID_W:0] next_v;
        next_v   = {1'b0, winner_s} + {{ID_W{1'b0}}, 1'b1};
        rr_ptr_d = rr_ptr_q;
        if ((state_q == ST_IDLE) && win_found_s) begin
            rr_ptr_d = (next_v == (ID_W+1)'(NUM_CONSUMERS)) ? '0 : next_v[ID_W-1:0];
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // Fixed priority pick: scanning downward leaves the lowest eligible index.
    always_comb begin
        win_found_s = 1'b0;
        winner_s    = '0;
        for (int i = NUM_CONSUMERS - 1; i >= 0; i--) begin
            winner_s    = eligible_s[i] ? ID_W'(i) : winner_s;
            win_found_s = win_found_s | eligible_s[i];
        end
    end
`endif

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_d                = state_q;
        grant_id_d             = grant_id_q;
        busy_d                 = busy_q;
        mem_read_valid_d       = mem_read_valid_q;
        mem_read_address_d     = mem_read_address_q;
        mem_write_valid_d      = mem_write_valid_q;
        mem_write_address_d    = mem_write_address_q;
        mem_write_data_d       = mem_write_data_q;
        consumer_read_ready_d  = consumer_read_ready_q;
        consumer_write_ready_d = consumer_write_ready_q;
        consumer_read_data_d   = consumer_read_data_q;

        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    grant_id_d = winner_s;
                    busy_d     = 1'b1;
                    // A read wins over a write from the same consumer.
                    if (consumer_read_valid[winner_s]) begin
                        mem_read_valid_d   = 1'b1;
                        mem_read_address_d = consumer_read_address[winner_s*ADDR_BITS +: ADDR_BITS];
                        state_d            = ST_READ_WAITING;
                    end else begin
                        mem_write_valid_d   = 1'b1;
                        mem_write_address_d = consumer_write_address[winner_s*ADDR_BITS +: ADDR_BITS];
                        mem_write_data_d    = consumer_write_data[winner_s*DATA_BITS +: DATA_BITS];
                        state_d             = ST_WRITE_WAITING;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ_WAITING: begin
                // Consumer valid is deliberately ignored here.
                if (mem_read_ready) begin
                    mem_read_valid_d                                      = 1'b0;
                    consumer_read_data_d[grant_id_q*DATA_BITS +: DATA_BITS] = mem_read_data;
                    consumer_read_ready_d[grant_id_q]                     = 1'b1;
                    state_d                                               = ST_READ_RELAYING;
                end else begin
                    state_d = ST_READ_WAITING;
                end
            end
            ST_WRITE_WAITING: begin
                if (mem_write_ready) begin
                    mem_write_valid_d                  = 1'b0;
                    consumer_write_ready_d[grant_id_q] = 1'b1;
                    state_d                            = ST_WRITE_RELAYING;
                end else begin
                    state_d = ST_WRITE_WAITING;
                end
            end
            ST_READ_RELAYING: begin
                // Read data stays in place after the handshake.
                if (!consumer_read_valid[grant_id_q]) begin
                    consumer_read_ready_d[grant_id_q] = 1'b0;
                    busy_d                            = 1'b0;
                    state_d                           = ST_IDLE;
                end else begin
                    state_d = ST_READ_RELAYING;
                end
            end
            ST_WRITE_RELAYING: begin
                if (!consumer_write_valid[grant_id_q]) begin
                    consumer_write_ready_d[grant_id_q] = 1'b0;
                    busy_d                             = 1'b0;
                    state_d                            = ST_IDLE;
                end else begin
                    state_d = ST_WRITE_RELAYING;
                end
            end
            default: begin
                // Unreachable encoding: drop any request and recover to idle.
                state_d                = ST_IDLE;
                busy_d                 = 1'b0;
                mem_read_valid_d       = 1'b0;
                mem_write_valid_d      = 1'b0;
                consumer_read_ready_d  = '0;
                consumer_write_ready_d = '0;
            end
        endcase
    end

    // State and registered-output flops; reset abandons any transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q                <= ST_IDLE;
            grant_id_q             <= '0;
            busy_q                 <= 1'b0;
            mem_read_valid_q       <= 1'b0;
            mem_read_address_q     <= '0;
            mem_write_valid_q      <= 1'b0;
            mem_write_address_q    <= '0;
            mem_write_data_q       <= '0;
            consumer_read_ready_q  <= '0;
            consumer_write_ready_q <= '0;
            consumer_read_data_q   <= '0;
        end else begin
            state_q                <= state_d;
            grant_id_q             <= grant_id_d;
            busy_q                 <= busy_d;
            mem_read_valid_q       <= mem_read_valid_d;
            mem_read_address_q     <= mem_read_address_d;
            mem_write_valid_q      <= mem_write_valid_d;
            mem_write_address_q    <= mem_write_address_d;
            mem_write_data_q       <= mem_write_data_d;
            consumer_read_ready_q  <= consumer_read_ready_d;
            consumer_write_ready_q <= consumer_write_ready_d;
            consumer_read_data_q   <= consumer_read_data_d;
        end
    end

    assign grant_id             = grant_id_q;
    assign busy                 = busy_q;
    assign mem_read_valid       = mem_read_valid_q;
    assign mem_read_address     = mem_read_address_q;
    assign mem_write_valid      = mem_write_valid_q;
    assign mem_write_address    = mem_write_address_q;
    assign mem_write_data       = mem_write_data_q;
    assign consumer_read_ready  = consumer_read_ready_q;
    assign consumer_write_ready = consumer_write_ready_q;
    assign consumer_read_data   = consumer_read_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (default parameters).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  crv, crr, cwv, cwr;
    logic [31:0] cra, cwa;
    logic [63:0] crd, cwd;
    logic        mrv, mrr, mwv, mwr;
    logic [7:0]  mra, mwa;
    logic [15:0] mrd, mwd;
    logic [1:0]  grant_id;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (crv),
        .consumer_read_address  (cra),
        .consumer_read_ready    (crr),
        .consumer_read_data     (crd),
        .consumer_write_valid   (cwv),
        .consumer_write_address (cwa),
        .consumer_write_data    (cwd),
        .consumer_write_ready   (cwr),
        .mem_read_valid         (mrv),
        .mem_read_address       (mra),
        .mem_read_ready         (mrr),
        .mem_read_data          (mrd),
        .mem_write_valid        (mwv),
        .mem_write_address      (mwa),
        .mem_write_data         (mwd),
        .mem_write_ready        (mwr),
        .grant_id               (grant_id),
        .busy                   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_tests++;
        if ({crr, crd, cwr, mrv, mra, mwv, mwa, mwd, grant_id, busy} !== 109'd0) begin
            n_fail++;
            $display("FAIL reset_state: got crr=%h crd=%h cwr=%h mrv=%b mwv=%b gid=%0d busy=%b want all 0",
                     crr, crd, cwr, mrv, mwv, grant_id, busy);
        end
        tick();
        reset = 1'b1;
    endtask

    task automatic test_single_read();
        crv[2] = 1'b1;
        cra[23:16] = 8'h3C;
        tick();
        n_tests++;
        if ({busy, grant_id, mrv, mra, mwv} !== {1'b1, 2'd2, 1'b1, 8'h3C, 1'b0}) begin
            n_fail++;
            $display("FAIL read_grant: got busy=%b gid=%0d mrv=%b mra=%h mwv=%b want 1 2 1 3c 0",
                     busy, grant_id, mrv, mra, mwv);
        end
        tick();
        n_tests++;
        if ({mrv, mra, crr} !== {1'b1, 8'h3C, 4'b0000}) begin
            n_fail++;
            $display("FAIL read_hold: got mrv=%b mra=%h crr=%b want 1 3c 0000", mrv, mra, crr);
        end
        mrr = 1'b1;
        mrd = 16'hBEEF;
        tick();
        mrr = 1'b0;
        mrd = 16'h0000;
        n_tests++;
        if ({mrv, crr, crd[47:32]} !== {1'b0, 4'b0100, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL read_relay: got mrv=%b crr=%b data=%h want 0 0100 beef", mrv, crr, crd[47:32]);
        end
        tick();
        n_tests++;
        if (crr !== 4'b0100) begin
            n_fail++;
            $display("FAIL read_ready_held: got crr=%b want 0100", crr);
        end
        crv[2] = 1'b0;
        tick();
        n_tests++;
        if ({crr, busy, crd[47:32]} !== {4'b0000, 1'b0, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL read_release: got crr=%b busy=%b data=%h want 0000 0 beef", crr, busy, crd[47:32]);
        end
        cra = 32'h0;
    endtask

    task automatic test_single_write();
        cwv[1] = 1'b1;
        cwa[15:8] = 8'h80;
        cwd[31:16] = 16'h1234;
        tick();
        n_tests++;
        if ({busy, grant_id, mwv, mwa, mwd, mrv} !== {1'b1, 2'd1, 1'b1, 8'h80, 16'h1234, 1'b0}) begin
            n_fail++;
            $display("FAIL write_grant: got busy=%b gid=%0d mwv=%b mwa=%h mwd=%h mrv=%b want 1 1 1 80 1234 0",
                     busy, grant_id, mwv, mwa, mwd, mrv);
        end
        tick();
        mwr = 1'b1;
        tick();
        mwr = 1'b0;
        n_tests++;
        if ({mwv, cwr, busy} !== {1'b0, 4'b0010, 1'b1}) begin
            n_fail++;
            $display("FAIL write_ack: got mwv=%b cwr=%b busy=%b want 0 0010 1", mwv, cwr, busy);
        end
        tick();
        n_tests++;
        if (cwr !== 4'b0010) begin
            n_fail++;
            $display("FAIL write_ack_held: got cwr=%b want 0010", cwr);
        end
        cwv[1] = 1'b0;
        tick();
        n_tests++;
        if ({cwr, busy} !== {4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL write_release: got cwr=%b busy=%b want 0000 0", cwr, busy);
        end
        cwa = 32'h0;
        cwd = 64'h0;
    endtask

    task automatic test_idle_mem_ready();
        mrr = 1'b1;
        mrd = 16'hDEAD;
        mwr = 1'b1;
        tick();
        mrr = 1'b0;
        mwr = 1'b0;
        mrd = 16'h0000;
        tick();
        n_tests++;
        if ({busy, crr, cwr, mrv, mwv, crd} !== {1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 16'h0, 16'hBEEF, 32'h0}) begin
            n_fail++;
            $display("FAIL idle_ready_ignored: got busy=%b crr=%b cwr=%b mrv=%b mwv=%b crd=%h want 0 0 0 0 0 0000beef00000000",
                     busy, crr, cwr, mrv, mwv, crd);
        end
    endtask

    task automatic test_read_write_same();
        crv[3] = 1'b1;
        cwv[3] = 1'b1;
        cra[31:24] = 8'h11;
        cwa[31:24] = 8'h22;
        cwd[63:48] = 16'h5A5A;
        tick();
        n_tests++;
        if ({grant_id, mrv, mra, mwv} !== {2'd3, 1'b1, 8'h11, 1'b0}) begin
            n_fail++;
            $display("FAIL rw_read_first: got gid=%0d mrv=%b mra=%h mwv=%b want 3 1 11 0", grant_id, mrv, mra, mwv);
        end
        mrr = 1'b1;
        mrd = 16'hCAFE;
        tick();
        mrr = 1'b0;
        n_tests++;
        if ({crr, cwr, crd[63:48]} !== {4'b1000, 4'b0000, 16'hCAFE}) begin
            n_fail++;
            $display("FAIL rw_read_relay: got crr=%b cwr=%b data=%h want 1000 0000 cafe", crr, cwr, crd[63:48]);
        end
        crv[3] = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({grant_id, busy, mwv, mwa, mwd, mrv} !== {2'd3, 1'b1, 1'b1, 8'h22, 16'h5A5A, 1'b0}) begin
            n_fail++;
            $display("FAIL rw_write_second: got gid=%0d busy=%b mwv=%b mwa=%h mwd=%h mrv=%b want 3 1 1 22 5a5a 0",
                     grant_id, busy, mwv, mwa, mwd, mrv);
        end
        mwr = 1'b1;
        tick();
        mwr = 1'b0;
        n_tests++;
        if ({cwr, crr} !== {4'b1000, 4'b0000}) begin
            n_fail++;
            $display("FAIL rw_write_ack: got cwr=%b crr=%b want 1000 0000", cwr, crr);
        end
        cwv[3] = 1'b0;
        tick();
        n_tests++;
        if ({busy, cwr} !== {1'b0, 4'b0000}) begin
            n_fail++;
            $display("FAIL rw_release: got busy=%b cwr=%b want 0 0000", busy, cwr);
        end
        cra = 32'h0;
        cwa = 32'h0;
        cwd = 64'h0;
    endtask

    task automatic test_reset_mid();
        crv[0] = 1'b1;
        cra[7:0] = 8'h44;
        tick();
        n_tests++;
        if ({mrv, grant_id, mra} !== {1'b1, 2'd0, 8'h44}) begin
            n_fail++;
            $display("FAIL mid_pre_reset: got mrv=%b gid=%0d mra=%h want 1 0 44", mrv, grant_id, mra);
        end
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({crr, crd, cwr, mrv, mra, mwv, mwa, mwd, grant_id, busy} !== 109'd0) begin
            n_fail++;
            $display("FAIL mid_reset_clear: got crr=%h crd=%h mrv=%b mra=%h gid=%0d busy=%b want all 0",
                     crr, crd, mrv, mra, grant_id, busy);
        end
        crv = 4'b0;
        cra = 32'h0;
        tick();
        reset = 1'b1;
        mrr = 1'b1;
        mrd = 16'h7777;
        tick();
        mrr = 1'b0;
        tick();
        n_tests++;
        if ({crr, busy, mrv, crd} !== {4'b0, 1'b0, 1'b0, 64'h0}) begin
            n_fail++;
            $display("FAIL mid_no_relay: got crr=%b busy=%b mrv=%b crd=%h want 0 0 0 0", crr, busy, mrv, crd);
        end
    endtask

    task automatic test_arbitration();
        int exp_order[5];
        int g;
        int cyc;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        crv = 4'hF;
        cra = {8'h33, 8'h22, 8'h11, 8'h00};
        for (int t = 0; t < 5; t++) begin
            g = exp_order[t];
            cyc = 0;
            while (!mrv && cyc < 8) begin
                tick();
                cyc++;
            end
            n_tests++;
            if ({mrv, grant_id, mra} !== {1'b1, 2'(g), 8'(g * 17)}) begin
                n_fail++;
                $display("FAIL arb_grant_%0d: got mrv=%b gid=%0d mra=%h want 1 %0d %h",
                         t, mrv, grant_id, mra, g, 8'(g * 17));
            end
            mrr = 1'b1;
            mrd = 16'h1000 + 16'(t);
            tick();
            mrr = 1'b0;
            n_tests++;
            if ({crr, crd[g*16 +: 16]} !== {4'(1 << g), 16'h1000 + 16'(t)}) begin
                n_fail++;
                $display("FAIL arb_relay_%0d: got crr=%b data=%h want %b %h",
                         t, crr, crd[g*16 +: 16], 4'(1 << g), 16'h1000 + 16'(t));
            end
            crv[g] = 1'b0;
            tick();
            if (t < 4) begin
                crv[g] = 1'b1;
            end else begin
                crv = 4'b0;
            end
        end
        tick();
        n_tests++;
        if ({busy, crr} !== {1'b0, 4'b0}) begin
            n_fail++;
            $display("FAIL arb_drain: got busy=%b crr=%b want 0 0000", busy, crr);
        end
    endtask

    initial begin
        reset = 1'b0;
        crv = 4'b0;
        cwv = 4'b0;
        cra = 32'h0;
        cwa = 32'h0;
        cwd = 64'h0;
        mrr = 1'b0;
        mwr = 1'b0;
        mrd = 16'h0;
        test_reset();
        test_single_read();
        test_single_write();
        test_idle_mem_ready();
        test_read_write_same();
        test_reset_mid();
        test_arbitration();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
